product_bcd_disp: RTL and testbench

//   Downstream consumer of the 4-bit multiplier's 8-bit product.

---
 rtl/product_bcd_disp_if.sv | 32 +++
 rtl/product_bcd_disp.sv | 216 +++++++++++++++++++++
 tb/tb_product_bcd_disp.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/product_bcd_disp_if.sv
// ---------------------------------------------------------------------------
// product_bcd_disp_if
//   Product handshake between the multiplier (source) and the BCD display
//   block (sink).
//
//   Handshake: a product transfers on a rising clock edge where
//   prod_valid && prod_ready are both high. prod is sampled only on that
//   edge. Once prod_valid is raised, the source holds prod stable until the
//   transfer edge. prod_valid seen while prod_ready is low is ignored.
//
//   Signals
//     prod_valid  source -> sink  prod carries a product this cycle
//     prod[7:0]   source -> sink  unsigned binary product, 0..255
//     prod_ready  sink -> source  sink can accept a product this cycle
// ---------------------------------------------------------------------------
interface product_bcd_disp_if;
  logic       prod_valid;
  logic [7:0] prod;
  logic       prod_ready;

  modport master (
    output prod_valid,
    output prod,
    input  prod_ready
  );

  modport slave (
    input  prod_valid,
    input  prod,
    output prod_ready
  );
endinterface

// File: rtl/product_bcd_disp.sv
// ---------------------------------------------------------------------------
// product_bcd_disp
//   Takes an 8-bit binary product over a valid/ready handshake. It converts
//   the product to 3-digit BCD with a sequential double-dabble (one bit per
//   clock) and drives a time-multiplexed 3-digit common-anode 7-segment
//   display. The display keeps showing the last finished conversion while a
//   new conversion runs.
//
//   Handshake: accept on the edge where prod_valid && prod_ready. The block
//   then takes 10 clocks per product. prod_ready rises again after the edge
//   that follows the bcd_valid pulse.
//
//   Parameters
//     SCAN_W       width of the digit-scan counter; each digit is lit for
//                  2**SCAN_W clocks
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     prod_if      slave side of the product handshake
//                  (prod_valid, prod, prod_ready)
//     bcd          {hundreds,tens,ones} of the last completed conversion
//     bcd_valid    one-clock pulse when bcd has just updated
//     seg          segments {g,f,e,d,c,b,a}, active-low
//     an           digit enables, active-low; an[0]=ones, an[1]=tens,
//                  an[2]=hundreds
//     dbg_state_o  current conversion FSM state (0=IDLE, 1=SHIFT, 2=DONE)
// ---------------------------------------------------------------------------
module product_bcd_disp #(
  parameter int SCAN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  product_bcd_disp_if.slave  prod_if,
  output logic [11:0]        bcd,
  output logic               bcd_valid,
  output logic [6:0]         seg,
  output logic [2:0]         an,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // ---------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------
  state_e      state_q;
  logic        ready_q;
  logic [7:0]  shreg_q;
  logic [11:0] scratch_q;
  logic [2:0]  bitcnt_q;
  logic [11:0] bcd_q;
  logic        bcd_valid_q;

  logic [11:0] scratch_adj;
  logic [11:0] scratch_d;
  logic [7:0]  shreg_d;

  // Nibble correction: a digit of 5 or more would pass 9 after the shift
  // doubles it. Adding 3 first makes the carry land in the next digit.
  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  always_comb begin
    scratch_adj = {dabble_adj(scratch_q[11:8]),
                   dabble_adj(scratch_q[7:4]),
                   dabble_adj(scratch_q[3:0])};
    // {scratch,shreg} shifts left as one 20-bit register
    scratch_d   = {scratch_adj[10:0], shreg_q[7]};
    shreg_d     = {shreg_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      shreg_q     <= 8'd0;
      scratch_q   <= 12'd0;
      bitcnt_q    <= 3'd0;
      bcd_q       <= 12'h000;
      bcd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (prod_if.prod_valid && ready_q) begin
            shreg_q   <= prod_if.prod;
            scratch_q <= 12'd0;
            bitcnt_q  <= 3'd0;
            ready_q   <= 1'b0;
            state_q   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch_q <= scratch_d;
          shreg_q   <= shreg_d;
          bitcnt_q  <= bitcnt_q + 3'd1;
          // bitcnt_q == 7 marks the 8th shift edge. The shifted scratch
          // is the finished BCD value.
          if (bitcnt_q == 3'd7) begin
            bcd_q       <= scratch_d;
            bcd_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          bcd_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign prod_if.prod_ready = ready_q;
  assign bcd                = bcd_q;
  assign bcd_valid          = bcd_valid_q;
  assign dbg_state_o        = state_q;

  // ---------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------
  logic [SCAN_W-1:0] scan_q;
  logic [1:0]        digit_q;
  logic [2:0]        an_q;
  logic [6:0]        seg_q;

  logic [1:0]        digit_d;
  logic [2:0]        an_d;
  logic [6:0]        seg_d;
  logic [3:0]        nib;
  logic              blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    digit_d = digit_q;
    // The digit index advances on the edge where the scan counter wraps
    if (&scan_q) begin
      digit_d = (digit_q == 2'd2) ? 2'd0 : (digit_q + 2'd1);
    end

    nib   = 4'd0;
    blank = 1'b0;
    an_d  = 3'b110;
    case (digit_d)
      2'd0: begin
        nib  = bcd_q[3:0];
        an_d = 3'b110;
      end
      2'd1: begin
        nib   = bcd_q[7:4];
        an_d  = 3'b101;
        blank = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        nib   = bcd_q[11:8];
        an_d  = 3'b011;
        blank = (bcd_q[11:8] == 4'd0);
      end
      default: begin
        nib   = 4'd0;
        an_d  = 3'b110;
        blank = 1'b1;
      end
    endcase

    seg_d = blank ? SEG_BLANK : seg_decode(nib);
  end

  // seg and an are built from the same next index, so they change together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q  <= '0;
      digit_q <= 2'd0;
      an_q    <= 3'b110;
      seg_q   <= 7'b1000000;
    end else begin
      scan_q  <= scan_q + {{(SCAN_W-1){1'b0}}, 1'b1};
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_product_bcd_disp.sv
// ---------------------------------------------------------------------------
// tb_product_bcd_disp
//   Self-checking bench for product_bcd_disp with SCAN_W=2. The expected BCD
//   and display patterns come from decimal arithmetic on the product value.
// ---------------------------------------------------------------------------
module tb_product_bcd_disp;
  localparam int SCAN_W = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  product_bcd_disp_if bus();
  logic [11:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic [1:0]  dbg_state;

  product_bcd_disp #(.SCAN_W(SCAN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prod_if     (bus),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid),
    .seg         (seg),
    .an          (an),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_bcd = 12'h000;
  logic [6:0]  seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int value_of(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  // d: 0=ones, 1=tens, 2=hundreds
  function automatic logic [6:0] exp_seg(input int v, input int d);
    int digit;
    if (d == 2 && v < 100) return 7'h7F;
    if (d == 1 && v < 10)  return 7'h7F;
    digit = (d == 0) ? (v % 10) : (d == 1) ? ((v / 10) % 10) : (v / 100);
    return seg_tbl[digit];
  endfunction

  function automatic logic [2:0] next_an(input logic [2:0] a);
    case (a)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  // ---------------- result monitor ----------------
  always @(negedge clk) begin : mon
    logic [11:0] e;
    if (rst_n && bcd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_bcd_valid", 32'(bcd_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("bcd", 32'(bcd), 32'(e));
        last_bcd = e;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag);
    int waited = 0;
    while (bus.prod_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (bus.prod_ready !== 1'b1) check_eq(tag, 32'(bus.prod_ready), 32'd1);
  endtask

  // Send one product and check handshake timing. Index k counts the
  // negedges after the accept edge.
  task automatic send(input logic [7:0] p);
    int          valid_at = 0;
    int          ready_at = 0;
    logic [11:0] prev;
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod       = p;
    wait_ready("accept_timeout");
    if (bus.prod_ready !== 1'b1) begin
      bus.prod_valid = 1'b0;
      return;
    end
    prev = last_bcd;
    exp_q.push_back(bcd_of(int'(p)));
    for (int k = 1; k <= 20 && ready_at == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.prod_valid = 1'b0;
        bus.prod       = 8'($urandom);
      end
      if (k == 5) check_eq("bcd_hold", 32'(bcd), 32'(prev));
      if (bcd_valid && valid_at == 0) valid_at = k;
      if (bus.prod_ready) ready_at = k;
    end
    check_eq("valid_latency", 32'(valid_at), 32'd9);
    check_eq("ready_latency", 32'(ready_at), 32'd10);
  endtask

  task automatic check_display(input int ncyc);
    logic [2:0] seen = 3'b000;
    int         v;
    int         d;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      v = value_of(last_bcd);
      case (an)
        3'b110:  d = 0;
        3'b101:  d = 1;
        3'b011:  d = 2;
        default: d = -1;
      endcase
      if (d < 0) begin
        check_eq("an_onehot", 32'(an), 32'(3'b110));
      end else begin
        check_eq($sformatf("seg_d%0d_v%0d", d, v), 32'(seg), 32'(exp_seg(v, d)));
        seen[d] = 1'b1;
      end
    end
    check_eq("an_all_digits", 32'(seen), 32'(3'b111));
  endtask

  // ---------------- stimulus ----------------
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0] prev_an;
    int         run_len;
    int         changes;
    int         k;

    bus.prod_valid = 1'b0;
    bus.prod       = 8'd0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check_eq("rst_ready", 32'(bus.prod_ready), 32'd1);
    check_eq("rst_bcd", 32'(bcd), 32'h000);
    check_eq("rst_bcd_valid", 32'(bcd_valid), 32'd0);
    check_eq("rst_an", 32'(an), 32'(3'b110));
    check_eq("rst_seg", 32'(seg), 32'(7'b1000000));
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // Test 1: idle scan order and dwell time
    prev_an = an;
    run_len = 0;
    changes = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      run_len++;
      if (an !== prev_an) begin
        check_eq("an_order", 32'(an), 32'(next_an(prev_an)));
        if (changes > 0) check_eq("an_period", 32'(run_len), 32'd4);
        changes++;
        run_len = 0;
        prev_an = an;
      end
    end
    check_eq("an_changes", 32'(changes >= 4), 32'd1);
    check_display(12);

    // Test 2: 15*15
    send(8'd225);
    check_display(12);

    // Test 3: blanking and range edges
    send(8'd9);
    check_display(12);
    send(8'd0);
    check_display(12);
    send(8'd255);
    check_display(12);

    // Test 4: prod_valid held high; prod changes mid-conversion
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod       = 8'd100;
    wait_ready("hold_accept_timeout");
    exp_q.push_back(bcd_of(100));
    k = 0;
    for (int i = 1; i <= 20 && k == 0; i++) begin
      @(negedge clk);
      if (i == 3) bus.prod = 8'd42;
      if (bus.prod_ready) k = i;
    end
    check_eq("hold_accept_gap", 32'(k), 32'd10);
    exp_q.push_back(bcd_of(42));
    @(negedge clk);
    bus.prod_valid = 1'b0;
    wait_ready("hold_done_timeout");
    check_display(12);

    // Test 5: reset during the 4th shift clock
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod       = 8'd123;
    wait_ready("rst_accept_timeout");
    exp_q.push_back(bcd_of(123));
    @(negedge clk);
    bus.prod_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_state_shift", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    last_bcd = 12'h000;
    #1;
    check_eq("mid_rst_ready", 32'(bus.prod_ready), 32'd1);
    check_eq("mid_rst_bcd", 32'(bcd), 32'h000);
    check_eq("mid_rst_valid", 32'(bcd_valid), 32'd0);
    check_eq("mid_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_display(12);
    check_eq("post_rst_bcd", 32'(bcd), 32'h000);
    send(8'd123);
    check_display(12);

    // Random products
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom_range(0, 255)));
      if (i % 6 == 0) check_display(12);
    end

    // Test 6: every 4-bit x 4-bit multiplier product
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        send(8'(a * b));
      end
    end
    check_display(12);

    repeat (3) @(negedge clk);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
